mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
- REQ-001 SHALL have parameter AW, default 8, meaning address width (memory depth 2**AW bytes).
- REQ-002 SHALL have parameter DW, default 8, meaning data width.
- REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
- REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-low.
- REQ-005 SHALL have port bus_in, input, DW, shared datapath bus value (address source for AR, write data source).
- REQ-006 SHALL have port AR_load, input, 1, load Address Register from bus_in[AW-1:0].
- REQ-007 SHALL have port memory_WE, input, 1, write bus_in to mem[AR].
- REQ-008 SHALL have port mem_out, output, DW, read data = mem[AR].
- REQ-009 SHALL have port ld_valid, input, 1, loader byte valid.
- REQ-010 SHALL have port ld_data, input, DW, loader byte.
- REQ-011 SHALL have port ld_last, input, 1, marks the final loader byte (qualified by ld_valid).
- REQ-012 SHALL have port ld_ready, output, 1, responder accepts loader bytes.
- REQ-013 SHALL have port ld_restart, input, 1, request to re-enter load mode.
- REQ-014 SHALL have port cpu_hold, output, 1, high while the CPU must stay in reset/stall.
- REQ-015 SHALL have port dev_ptr, output, AW, current load pointer (debug).

Function
- REQ-016 SHALL implement a 2-state FSM: LOAD, RUN.
- REQ-017 In LOAD: ld_ready=1, cpu_hold=1; AR_load and memory_WE are ignored.
- REQ-018 In LOAD, on ld_valid&ld_ready: mem[ptr] <= ld_data, ptr <= ptr+1 (mod 2**AW).
- REQ-019 LOAD->RUN on the cycle after an accepted byte with ld_last=1, or after an accepted byte written at ptr=2**AW-1 (wrap); ptr then reads 0.
- REQ-020 In RUN: ld_ready=0, cpu_hold=0; ld_valid ignored.
- REQ-021 In RUN, AR_load=1: AR <= bus_in[AW-1:0] on the same edge.
- REQ-022 In RUN, memory_WE=1: mem[AR] <= bus_in using AR value before that edge.
- REQ-023 AR_load and memory_WE together: write uses old AR; AR updates; both take effect on that edge.
- REQ-024 mem_out SHALL be a combinational (asynchronous) read of mem[AR]; zero-cycle latency after AR changes, and reflects a write to mem[AR] the cycle after the write edge.
- REQ-025 RUN->LOAD when ld_restart=1; ptr <= 0, AR unchanged; takes priority over a concurrent memory_WE (write suppressed).
- REQ-026 ld_restart in LOAD SHALL reset ptr to 0 and discard any byte offered that cycle.
- REQ-027 In LOAD, ld_last without ld_valid SHALL have no effect.

Reset
- REQ-028 rst=0 at a rising edge: state<=LOAD, ptr<=0, AR<=0; outputs then ld_ready=1, cpu_hold=1, dev_ptr=0, mem_out=mem[0].
- REQ-029 Memory contents SHALL NOT be cleared by reset; reset mid-load discards only the pointer.
- REQ-030 Reset SHALL override every other input on the same edge.

Structure
- REQ-031 Shared package SHALL hold state encoding (LOAD=1'b0, RUN=1'b1) and default AW/DW constants, shared with the CPU control unit.
- REQ-032 Storage SHALL be a sub-module ram_sp_async (one write port, one async read port) so it maps to distributed RAM.
- REQ-033 FSM, ptr, AR and write-port muxing (loader vs CPU) SHALL live in mem_responder.

Verification
- REQ-034 Reset, then load 0x11,0x22,0x33 with ld_last on 0x33 -> next cycle cpu_hold=0, ld_ready=0; mem[0..2]=11,22,33.
- REQ-035 RUN: bus_in=0x02, AR_load=1 -> same cycle after edge mem_out=0x33; then bus_in=0xA5, memory_WE=1 -> mem_out=0xA5 next cycle.
- REQ-036 RUN: AR=0x01, bus_in=0x00 with AR_load=1 and memory_WE=1 -> mem[1]=0x00, AR=0x00, mem_out=0x11.
- REQ-037 Load 256 bytes without ld_last -> after byte at 0xFF, RUN entered, dev_ptr=0x00.
- REQ-038 RUN: ld_restart=1 with memory_WE=1 at AR=0x00 -> mem[0] unchanged (0x11), state LOAD, dev_ptr=0.
- REQ-039 Mid-load after 2 bytes assert rst=0 -> ptr=0, LOAD, mem[0..1] retained; AR_load/memory_WE in LOAD -> no change.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared constants and state encoding for the memory responder
// Purpose: default address/data widths and the LOAD/RUN state encoding, shared
//          with the CPU control unit so both sides agree on the responder mode.
package mem_responder_pkg;

  localparam int DEFAULT_AW = 8;
  localparam int DEFAULT_DW = 8;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage : mem_responder_pkg

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU datapath and loader signal bundle for the memory responder
// Purpose: groups the shared bus, AR/write controls, loader stream and status outputs.
// Ports (signals):
//   bus_in, AR_load, memory_WE  : CPU datapath side (master drives)
//   mem_out                     : async read data at AR (slave drives)
//   ld_valid, ld_data, ld_last  : loader byte stream (master drives)
//   ld_ready                    : loader accept (slave drives)
//   ld_restart                  : re-enter load mode (master drives)
//   cpu_hold, dev_ptr           : CPU stall and load pointer (slave drives)
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
);

  logic [DW-1:0] bus_in;
  logic          AR_load;
  logic          memory_WE;
  logic [DW-1:0] mem_out;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_restart;
  logic          cpu_hold;
  logic [AW-1:0] dev_ptr;

  modport master (
    output bus_in, AR_load, memory_WE, ld_valid, ld_data, ld_last, ld_restart,
    input  mem_out, ld_ready, cpu_hold, dev_ptr
  );

  modport slave (
    input  bus_in, AR_load, memory_WE, ld_valid, ld_data, ld_last, ld_restart,
    output mem_out, ld_ready, cpu_hold, dev_ptr
  );

endinterface : mem_responder_if

// File: rtl/ram_sp_async.sv
// rtl/ram_sp_async.sv - single write port, asynchronous read port RAM
// Purpose: storage array intended for distributed RAM; contents are never reset.
// Ports:
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address (combinational read)
//   o_rdata : read data
module ram_sp_async #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : ram_sp_async

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - boot loader / CPU memory responder with LOAD and RUN modes
// Purpose: in LOAD the loader stream fills memory sequentially while the CPU is held;
//          in RUN the CPU datapath owns the address register and write port.
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-low reset (memory contents retained)
//   bus : mem_responder_if.slave (datapath, loader stream, status)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  state_e        r_state;
  state_e        w_state_next;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_next;
  logic [AW-1:0] r_ar;
  logic [AW-1:0] w_ar_next;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic [AW-1:0] w_bus_addr;

  assign w_bus_addr = AW'(bus.bus_in);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_LOAD;
      r_ptr   <= '0;
      r_ar    <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_ar    <= w_ar_next;
    end
  end

  // Next state and write-port mux. ld_restart wins over any write in either mode.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_ar_next    = r_ar;
    w_we         = 1'b0;
    w_waddr      = r_ar;
    w_wdata      = bus.bus_in;
    unique case (r_state)
      ST_LOAD: begin
        if (bus.ld_restart) begin
          w_ptr_next = '0;
        end else if (bus.ld_valid) begin
          w_we       = 1'b1;
          w_waddr    = r_ptr;
          w_wdata    = bus.ld_data;
          w_ptr_next = r_ptr + 1'b1;
          // Leaving on the top byte makes the pointer wrap to 0 on entry to RUN.
          if (bus.ld_last || (r_ptr == '1)) begin
            w_state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.ld_restart) begin
          w_state_next = ST_LOAD;
          w_ptr_next   = '0;
        end else begin
          // The write uses the pre-edge AR even when AR_load is also asserted.
          w_we = bus.memory_WE;
          if (bus.AR_load) begin
            w_ar_next = w_bus_addr;
          end
        end
      end
      default: begin
        w_state_next = ST_LOAD;
      end
    endcase
    // Reset must also block the write that would otherwise land on the same edge.
    if (!rst) begin
      w_we = 1'b0;
    end
  end

  ram_sp_async #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_ar),
    .o_rdata (bus.mem_out)
  );

  assign bus.ld_ready = (r_state == ST_LOAD);
  assign bus.cpu_hold = (r_state == ST_LOAD);
  assign bus.dev_ptr  = r_ptr;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
module tb_mem_responder;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_responder_if #(.AW(AW), .DW(DW)) bus_if ();

  mem_responder #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the memory as an array, the mode as a flag, plain integer pointers.
  int  m_mem [DEPTH];
  bit  m_run;
  int  m_ptr;
  int  m_ar;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit arl, input bit we, input int bus,
                            input bit vld, input int data, input bit last, input bit rs);
    if (!r) begin
      m_run = 0; m_ptr = 0; m_ar = 0;
    end else if (!m_run) begin
      if (rs) begin
        m_ptr = 0;
      end else if (vld) begin
        m_mem[m_ptr] = data;
        if (last || m_ptr == DEPTH - 1) m_run = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end else begin
      if (rs) begin
        m_run = 0; m_ptr = 0;
      end else begin
        if (we) m_mem[m_ar] = bus;
        if (arl) m_ar = bus % DEPTH;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".ld_ready"}, 32'(bus_if.ld_ready), 32'(!m_run));
    check({tag, ".cpu_hold"}, 32'(bus_if.cpu_hold), 32'(!m_run));
    check({tag, ".dev_ptr"},  32'(bus_if.dev_ptr),  32'(m_ptr));
    check({tag, ".mem_out"},  32'(bus_if.mem_out),  32'(m_mem[m_ar]));
  endtask

  // One clock: apply inputs, advance the model at the edge, sample 1ns later.
  task automatic cycle(input string tag, input bit r, input bit arl, input bit we,
                       input int bus, input bit vld, input int data, input bit last,
                       input bit rs, input bit cmp);
    rst               = r;
    bus_if.AR_load    = arl;
    bus_if.memory_WE  = we;
    bus_if.bus_in     = DW'(bus);
    bus_if.ld_valid   = vld;
    bus_if.ld_data    = DW'(data);
    bus_if.ld_last    = last;
    bus_if.ld_restart = rs;
    @(posedge clk);
    model_step(r, arl, we, bus, vld, data, last, rs);
    #1;
    if (cmp) compare_all(tag);
  endtask

  task automatic load_byte(input string tag, input int data, input bit last);
    cycle(tag, 1, 0, 0, 0, 1, data, last, 0, 1);
  endtask

  initial begin
    bus_if.bus_in = '0; bus_if.AR_load = 0; bus_if.memory_WE = 0;
    bus_if.ld_valid = 0; bus_if.ld_data = '0; bus_if.ld_last = 0; bus_if.ld_restart = 0;
    m_run = 0; m_ptr = 0; m_ar = 0;

    // Reset state (memory contents unknown, so mem_out is not compared yet)
    cycle("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("reset", 0, 1, 1, 8'h5A, 1, 8'h99, 1, 0, 0);
    check("reset.ld_ready", 32'(bus_if.ld_ready), 32'd1);
    check("reset.cpu_hold", 32'(bus_if.cpu_hold), 32'd1);
    check("reset.dev_ptr",  32'(bus_if.dev_ptr),  32'd0);

    // Full 256-byte load without ld_last: wraps into RUN with pointer 0
    for (int i = 0; i < DEPTH; i++) begin
      rst = 1; bus_if.AR_load = 0; bus_if.memory_WE = 0; bus_if.ld_restart = 0;
      bus_if.ld_valid = 1; bus_if.ld_last = 0; bus_if.ld_data = DW'($urandom);
      @(posedge clk);
      model_step(1, 0, 0, 0, 1, int'(bus_if.ld_data), 0, 0);
      #1;
    end
    check("wrap.cpu_hold", 32'(bus_if.cpu_hold), 32'd0);
    check("wrap.ld_ready", 32'(bus_if.ld_ready), 32'd0);
    check("wrap.dev_ptr",  32'(bus_if.dev_ptr),  32'd0);
    compare_all("wrap");

    // Restart and load 11,22,33 with ld_last on the third byte
    cycle("restart", 1, 0, 0, 0, 0, 0, 0, 1, 1);
    check("restart.cpu_hold", 32'(bus_if.cpu_hold), 32'd1);
    load_byte("ld0", 8'h11, 0);
    cycle("last_no_valid", 1, 0, 0, 0, 0, 0, 1, 0, 1);
    check("last_no_valid.hold", 32'(bus_if.cpu_hold), 32'd1);
    load_byte("ld1", 8'h22, 0);
    load_byte("ld2", 8'h33, 1);
    check("ld_last.cpu_hold", 32'(bus_if.cpu_hold), 32'd0);
    check("ld_last.ld_ready", 32'(bus_if.ld_ready), 32'd0);

    // AR load then write
    cycle("arload", 1, 1, 0, 8'h02, 0, 0, 0, 0, 1);
    check("arload.mem2", 32'(bus_if.mem_out), 32'h33);
    cycle("write", 1, 0, 1, 8'hA5, 0, 0, 0, 0, 1);
    check("write.mem2", 32'(bus_if.mem_out), 32'hA5);

    // Concurrent AR_load + memory_WE: write uses old AR
    cycle("ar1", 1, 1, 0, 8'h01, 0, 0, 0, 0, 1);
    check("ar1.mem1", 32'(bus_if.mem_out), 32'h22);
    cycle("both", 1, 1, 1, 8'h00, 0, 0, 0, 0, 1);
    check("both.mem0", 32'(bus_if.mem_out), 32'h11);
    cycle("rd1", 1, 1, 0, 8'h01, 0, 0, 0, 0, 1);
    check("both.mem1", 32'(bus_if.mem_out), 32'h00);
    cycle("ar0", 1, 1, 0, 8'h00, 0, 0, 0, 0, 1);

    // Restart beats a concurrent write
    cycle("rs_we", 1, 0, 1, 8'h77, 0, 0, 0, 1, 1);
    check("rs_we.mem0", 32'(bus_if.mem_out), 32'h11);
    check("rs_we.cpu_hold", 32'(bus_if.cpu_hold), 32'd1);
    check("rs_we.dev_ptr", 32'(bus_if.dev_ptr), 32'd0);

    // Restart in LOAD discards the offered byte
    load_byte("mid0", 8'hC1, 0);
    cycle("rs_load", 1, 0, 0, 0, 1, 8'hEE, 0, 1, 1);
    check("rs_load.dev_ptr", 32'(bus_if.dev_ptr), 32'd0);
    check("rs_load.mem0", 32'(bus_if.mem_out), 32'hC1);

    // Reset mid-load keeps memory, clears pointer; CPU controls ignored in LOAD
    load_byte("mid0", 8'hC1, 0);
    load_byte("mid1", 8'hC2, 0);
    cycle("midrst", 0, 0, 0, 0, 1, 8'hDD, 0, 0, 1);
    check("midrst.dev_ptr", 32'(bus_if.dev_ptr), 32'd0);
    check("midrst.mem0", 32'(bus_if.mem_out), 32'hC1);
    cycle("load_cpu", 1, 1, 1, 8'h05, 0, 0, 0, 0, 1);
    check("load_cpu.mem0", 32'(bus_if.mem_out), 32'hC1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle("rand", ($urandom_range(0, 40) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            int'($urandom_range(0, 255)), $urandom_range(0, 1), int'($urandom_range(0, 255)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 20) == 0), 1);
    end

    // Final sweep of every location through AR in RUN
    cycle("to_load", 1, 0, 0, 0, 0, 0, 0, 1, 1);
    load_byte("to_run", m_mem[0], 1);
    for (int a = 0; a < DEPTH; a++) begin
      cycle("sweep", 1, 1, 0, a, 0, 0, 0, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_responder
